// File: rtl/lif_spike_aer_out.sv
// Spike-to-AER output stage: queues spiking neuron addresses from the LIF update
// stream and emits them one at a time over a 4-phase AER request/acknowledge link.
module lif_spike_aer_out #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              evt_valid,
    input  logic [ADDR_W-1:0] evt_neur,
    input  logic [6:0]        evt_out,
    output logic [ADDR_W-1:0] AEROUT_ADDR,
    output logic              AEROUT_REQ,
    input  logic              AEROUT_ACK,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ_HI  = 2'd1;
    localparam logic [1:0] ST_WAIT_LO = 2'd2;

    logic [ADDR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [7:0]        drop_cnt_reg;
    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic              req_reg;
    logic              req_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              ack_meta_reg;
    logic              ack_s_reg;

    logic push_req;
    logic push_ok;
    logic pop;

    // Only the spike flag matters; the remaining LIF event bits are deliberately unused.
    logic unused_evt_bits;
    assign unused_evt_bits = ^evt_out[5:0];

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);

    assign push_req = evt_valid && evt_out[6] && !RST;
    // A full FIFO still accepts a spike when the head leaves in the same cycle.
    assign push_ok  = push_req && (!fifo_full || pop);

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && !ack_s_reg) begin
                    pop        = 1'b1;
                    req_next   = 1'b1;
                    state_next = ST_REQ_HI;
                end
            end
            ST_REQ_HI: begin
                if (ack_s_reg) begin
                    req_next   = 1'b0;
                    state_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                req_next = 1'b0;
                if (!ack_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Storage has no reset so it maps onto plain RAM; the pointers define validity.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= evt_neur;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_meta_reg <= 1'b0;
            ack_s_reg    <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= 8'd0;
            state_reg    <= ST_IDLE;
            req_reg      <= 1'b0;
            addr_reg     <= '0;
        end else begin
            ack_meta_reg <= AEROUT_ACK;
            ack_s_reg    <= ack_meta_reg;
            state_reg    <= state_next;
            req_reg      <= req_next;
            count_reg    <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                addr_reg   <= mem[rd_ptr_reg];
            end
            if (push_req && !push_ok && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign AEROUT_ADDR = addr_reg;
    assign AEROUT_REQ  = req_reg;
    assign drop_cnt    = drop_cnt_reg;

endmodule
